// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM for the 4-input MaxNet datapath; `MAXNET_TIMEOUT_EN enables the MAX_ITER timeout
module maxnet_controller #(
  parameter int WIDTH      = 5,
  parameter int PU_LATENCY = 1,
  parameter int MAX_ITER   = 15,
  parameter int ITER_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done,
  input  logic [WIDTH-1:0]  winner,
  output logic              ld_t,
  output logic              sel_t,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [WIDTH-1:0]  result,
  output logic [ITER_W-1:0] iter_count,
  output logic              timeout
);
  localparam int CW = PU_LATENCY > 1 ? $clog2(PU_LATENCY) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, UPDATE, FINISH} state_t;
  state_t state;
  logic [CW-1:0] wcnt;
  logic limit;
`ifdef MAXNET_TIMEOUT_EN
  assign limit = iter_count == ITER_W'(MAX_ITER);
`else
  localparam int unused_max_iter = MAX_ITER;
  assign limit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      wcnt         <= '0;
      ld_t         <= 1'b0;
      sel_t        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      iter_count   <= '0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= LOAD;
          ld_t       <= 1'b1;
          sel_t      <= 1'b0;
          busy       <= 1'b1;
          iter_count <= '0;
          timeout    <= 1'b0;
        end
        LOAD: begin
          state <= WAIT;
          ld_t  <= 1'b0;
          wcnt  <= CW'(PU_LATENCY - 1);
        end
        WAIT: if (wcnt == '0) state <= CHECK;
              else wcnt <= wcnt - 1'b1;
        CHECK: if (done || limit) begin
          state        <= FINISH;
          result       <= winner;
          result_valid <= 1'b1;
          timeout      <= !done;
        end else begin
          state <= UPDATE;
          ld_t  <= 1'b1;
          sel_t <= 1'b1;
        end
        UPDATE: begin
          state      <= WAIT;
          ld_t       <= 1'b0;
          sel_t      <= 1'b0;
          wcnt       <= CW'(PU_LATENCY - 1);
          iter_count <= iter_count + ITER_W'(~&iter_count);
        end
        FINISH: if (result_ready) begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: directed vector table plus multi-cycle sequences for PU_LATENCY 1 and 3
module tb_maxnet_controller;
  logic clk, rst;
  logic start, done, result_ready;
  logic [4:0] winner;
  logic ld_t, sel_t, busy, result_valid, timeout;
  logic [4:0] result;
  logic [3:0] iter_count;
  logic start3, done3, ready3;
  logic [4:0] winner3;
  logic ld3, sel3, busy3, rv3, to3;
  logic [4:0] result3;
  logic [3:0] iter3;
  int n_chk, n_fail, idx, upd, pulses;

  typedef struct {
    logic start, done, ready;
    logic [4:0] winner;
    logic ld, sel, busy, rv;
    logic [4:0] res;
    logic [3:0] iter;
  } vec_t;
  vec_t v[24];

  maxnet_controller #(.WIDTH(5), .PU_LATENCY(1), .MAX_ITER(15), .ITER_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .done(done), .winner(winner),
    .ld_t(ld_t), .sel_t(sel_t), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .iter_count(iter_count), .timeout(timeout));

  maxnet_controller #(.WIDTH(5), .PU_LATENCY(3), .MAX_ITER(15), .ITER_W(4)) u3 (
    .clk(clk), .rst(rst), .start(start3), .done(done3), .winner(winner3),
    .ld_t(ld3), .sel_t(sel3), .busy(busy3), .result_valid(rv3),
    .result_ready(ready3), .result(result3), .iter_count(iter3), .timeout(to3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ld_t"}, int'(ld_t), 0);
    chk({tag, " sel_t"}, int'(sel_t), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " result_valid"}, int'(result_valid), 0);
    chk({tag, " result"}, int'(result), 0);
    chk({tag, " iter_count"}, int'(iter_count), 0);
    chk({tag, " timeout"}, int'(timeout), 0);
    chk({tag, " u3 busy"}, int'(busy3), 0);
  endtask

  initial begin
    v[0]  = '{1'b1, 1'b1, 1'b1, 5'd19, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  4'd0};
    v[1]  = '{1'b0, 1'b1, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  4'd0};
    v[2]  = '{1'b0, 1'b1, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  4'd0};
    v[3]  = '{1'b0, 1'b1, 1'b1, 5'd19, 1'b0, 1'b0, 1'b1, 1'b1, 5'd19, 4'd0};
    v[4]  = '{1'b1, 1'b1, 1'b1, 5'd19, 1'b0, 1'b0, 1'b0, 1'b0, 5'd19, 4'd0};
    v[5]  = '{1'b1, 1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 5'd19, 4'd0};
    v[6]  = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd0};
    v[7]  = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd0};
    v[8]  = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 5'd19, 4'd0};
    v[9]  = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd1};
    v[10] = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd1};
    v[11] = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 5'd19, 4'd1};
    v[12] = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd2};
    v[13] = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd2};
    v[14] = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 5'd19, 4'd2};
    v[15] = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd3};
    v[16] = '{1'b0, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 5'd19, 4'd3};
    v[17] = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  4'd3};
    v[18] = '{1'b1, 1'b1, 1'b0, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  4'd3};
    v[19] = '{1'b0, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  4'd3};
    v[20] = '{1'b1, 1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  4'd3};
    v[21] = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  4'd3};
    v[22] = '{1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  4'd3};
    v[23] = '{1'b0, 1'b0, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0, 1'b0, 5'd7,  4'd3};
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0; done = 1'b0; result_ready = 1'b0; winner = '0;
    start3 = 1'b0; done3 = 1'b0; ready3 = 1'b0; winner3 = '0;
    repeat (2) step;
    chk_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      start = v[i].start;
      done = v[i].done;
      result_ready = v[i].ready;
      winner = v[i].winner;
      step;
      chk($sformatf("row%0d ld_t", i), int'(ld_t), int'(v[i].ld));
      chk($sformatf("row%0d sel_t", i), int'(sel_t), int'(v[i].sel));
      chk($sformatf("row%0d busy", i), int'(busy), int'(v[i].busy));
      chk($sformatf("row%0d result_valid", i), int'(result_valid), int'(v[i].rv));
      chk($sformatf("row%0d result", i), int'(result), int'(v[i].res));
      chk($sformatf("row%0d iter_count", i), int'(iter_count), int'(v[i].iter));
      chk($sformatf("row%0d timeout", i), int'(timeout), 0);
    end

    // abort mid-WAIT with an asynchronous reset between edges
    start = 1'b1; done = 1'b0; result_ready = 1'b0;
    step;
    start = 1'b0;
    chk("restart ld_t", int'(ld_t), 1);
    chk("restart iter cleared", int'(iter_count), 0);
    step;
    chk("wait busy", int'(busy), 1);
    chk("wait ld_t", int'(ld_t), 0);
    #2 rst = 1'b0;
    #1 chk_zero("async reset");
    rst = 1'b1;

    done = 1'b1; winner = 5'd19; start = 1'b1;
    step;
    start = 1'b0;
    idx = 0;
    while (!result_valid && idx < 20) begin
      step;
      idx++;
    end
    chk("post-reset latency", idx, 3);
    chk("post-reset result", int'(result), 19);
    result_ready = 1'b1;
    step;
    chk("post-reset idle busy", int'(busy), 0);
    result_ready = 1'b0;

    // PU_LATENCY=3 instance: one UPDATE then done
    done3 = 1'b0; winner3 = 5'd21; start3 = 1'b1;
    step;
    start3 = 1'b0;
    chk("p3 load ld_t", int'(ld3), 1);
    idx = 0;
    upd = -1;
    while (!rv3 && idx < 40) begin
      step;
      idx++;
      if (ld3 && sel3 && upd < 0) begin
        upd = idx;
        done3 = 1'b1;
      end
    end
    chk("p3 update index", upd, 5);
    chk("p3 finish index", idx, 10);
    chk("p3 result", int'(result3), 21);
    chk("p3 iter_count", int'(iter3), 1);
    ready3 = 1'b1;
    step;
    chk("p3 idle busy", int'(busy3), 0);

    // done never arrives
    done = 1'b0; winner = 5'd3; result_ready = 1'b0; start = 1'b1;
    step;
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 200; c++) begin
      step;
      if (ld_t && sel_t) pulses++;
`ifdef MAXNET_TIMEOUT_EN
      if (result_valid) break;
`else
      if (pulses == 20) break;
`endif
    end
    chk("no-done iter_count", int'(iter_count), 15);
`ifdef MAXNET_TIMEOUT_EN
    chk("timeout pulses", pulses, 15);
    chk("timeout flag", int'(timeout), 1);
    chk("timeout result", int'(result), 3);
    chk("timeout valid", int'(result_valid), 1);
`else
    chk("saturate pulses", pulses, 20);
    chk("saturate timeout", int'(timeout), 0);
    chk("saturate busy", int'(busy), 1);
    chk("saturate valid", int'(result_valid), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
